// File: rtl/painterengine_gpu_dma_reader_arbiter_if.sv
// rtl/painterengine_gpu_dma_reader_arbiter_if.sv - client and reader signals of the shared DMA reader arbiter
interface painterengine_gpu_dma_reader_arbiter_if;
  logic [3:0]   i_wire_req;
  logic [127:0] i_wire_address;
  logic [127:0] i_wire_length;
  logic [3:0]   o_wire_ack;
  logic         o_wire_error;
  logic [2:0]   o_wire_error_type;
  logic [3:0]   o_wire_grant;
  logic         o_wire_busy;
  logic         o_wire_reader_resetn;
  logic [3:0]   o_wire_reader_router;
  logic [127:0] o_wire_reader_address;
  logic [127:0] o_wire_reader_length;
  logic         i_wire_reader_done;
  logic         i_wire_reader_error;
  logic [2:0]   i_wire_reader_error_type;

  modport master (
    input  i_wire_req, i_wire_address, i_wire_length,
    input  i_wire_reader_done, i_wire_reader_error, i_wire_reader_error_type,
    output o_wire_ack, o_wire_error, o_wire_error_type, o_wire_grant, o_wire_busy,
    output o_wire_reader_resetn, o_wire_reader_router, o_wire_reader_address, o_wire_reader_length
  );

  modport slave (
    output i_wire_req, i_wire_address, i_wire_length,
    output i_wire_reader_done, i_wire_reader_error, i_wire_reader_error_type,
    input  o_wire_ack, o_wire_error, o_wire_error_type, o_wire_grant, o_wire_busy,
    input  o_wire_reader_resetn, o_wire_reader_router, o_wire_reader_address, o_wire_reader_length
  );
endinterface

// File: rtl/painterengine_gpu_dma_reader_arbiter.sv
// rtl/painterengine_gpu_dma_reader_arbiter.sv - round-robin sharing of one DMA reader among four clients
module painterengine_gpu_dma_reader_arbiter #(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int WATCHDOG_BITS     = 20
) (
  input  logic i_wire_clock,
  input  logic i_wire_resetn,
  painterengine_gpu_dma_reader_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, COMPLETE, RECOVER} state_t;

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 2) ? $clog2(RESET_HOLD_CYCLES) : 1;

  state_t                   state, state_next;
  logic [1:0]               rr_ptr, win_idx, owner_idx;
  logic                     win_found;
  logic [WATCHDOG_BITS-1:0] watchdog;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     wd_expired, hold_last, job_end;
  logic [3:0]               grant;

  assign wd_expired = &watchdog;
  // The IDLE cycle that relaunches the reader is the final reset-hold cycle, so RECOVER spans one fewer.
  assign hold_last  = (hold_cnt == HOLD_W'(RESET_HOLD_CYCLES - 2));
  assign job_end    = bus.i_wire_reader_error || bus.i_wire_reader_done || wd_expired;
  assign bus.o_wire_grant = grant;

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && bus.i_wire_req[rr_ptr + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = rr_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (win_found) state_next = RUN;
      RUN:      if (job_end) state_next = COMPLETE;
      COMPLETE: state_next = (RESET_HOLD_CYCLES > 1) ? RECOVER : IDLE;
      RECOVER:  if (hold_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state <= IDLE;
    else                state <= state_next;
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      rr_ptr                    <= 2'd0;
      owner_idx                 <= 2'd0;
      watchdog                  <= '0;
      hold_cnt                  <= '0;
      grant                     <= 4'd0;
      bus.o_wire_ack            <= 4'd0;
      bus.o_wire_error          <= 1'b0;
      bus.o_wire_error_type     <= 3'd0;
      bus.o_wire_busy           <= 1'b0;
      bus.o_wire_reader_resetn  <= 1'b0;
      bus.o_wire_reader_router  <= 4'd0;
      bus.o_wire_reader_address <= '0;
      bus.o_wire_reader_length  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            owner_idx                 <= win_idx;
            grant                     <= 4'b0001 << win_idx;
            bus.o_wire_reader_router  <= 4'b0001 << win_idx;
            bus.o_wire_busy           <= 1'b1;
            bus.o_wire_reader_resetn  <= 1'b1;
            watchdog                  <= '0;
            bus.o_wire_reader_address <= '0;
            bus.o_wire_reader_length  <= '0;
            bus.o_wire_reader_address[{win_idx, 5'd0} +: 32] <= bus.i_wire_address[{win_idx, 5'd0} +: 32];
            bus.o_wire_reader_length[{win_idx, 5'd0} +: 32]  <= bus.i_wire_length[{win_idx, 5'd0} +: 32];
          end
        end
        RUN: begin
          if (!wd_expired) watchdog <= watchdog + 1'b1;
          if (job_end) bus.o_wire_ack <= grant;
          // Error outranks done; the watchdog only fires when the reader reports nothing.
          if (bus.i_wire_reader_error) begin
            bus.o_wire_error      <= 1'b1;
            bus.o_wire_error_type <= bus.i_wire_reader_error_type;
          end else if (bus.i_wire_reader_done) begin
            bus.o_wire_error      <= 1'b0;
            bus.o_wire_error_type <= 3'd0;
          end else if (wd_expired) begin
            bus.o_wire_error      <= 1'b1;
            bus.o_wire_error_type <= 3'b111;
          end
        end
        COMPLETE: begin
          bus.o_wire_ack            <= 4'd0;
          bus.o_wire_error          <= 1'b0;
          bus.o_wire_error_type     <= 3'd0;
          bus.o_wire_reader_resetn  <= 1'b0;
          rr_ptr                    <= owner_idx + 2'd1;
          watchdog                  <= '0;
          hold_cnt                  <= '0;
          grant                     <= 4'd0;
          bus.o_wire_reader_router  <= 4'd0;
          bus.o_wire_reader_address <= '0;
          bus.o_wire_reader_length  <= '0;
          if (RESET_HOLD_CYCLES <= 1) bus.o_wire_busy <= 1'b0;
        end
        RECOVER: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_last) bus.o_wire_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_painterengine_gpu_dma_reader_arbiter.sv
// tb/tb_painterengine_gpu_dma_reader_arbiter.sv - directed checks of the DMA reader arbiter
module tb_painterengine_gpu_dma_reader_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;
  logic [3:0] exp_oh;

  painterengine_gpu_dma_reader_arbiter_if bus();

  painterengine_gpu_dma_reader_arbiter #(.RESET_HOLD_CYCLES(2), .WATCHDOG_BITS(6)) dut (
    .i_wire_clock (clk),
    .i_wire_resetn(resetn),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.o_wire_busy; i++) tick();
    check("idle_reached", bus.o_wire_busy, 1'b0);
    tick();
  endtask

  task automatic finish_job();
    bus.i_wire_reader_done = 1'b1;
    tick();
    bus.i_wire_reader_done = 1'b0;
  endtask

  initial begin
    bus.i_wire_req = 4'd0;
    bus.i_wire_address = {32'hAAAA0003, 32'h00001000, 32'hCCCC0001, 32'hDDDD0000};
    bus.i_wire_length  = {32'd7, 32'd16, 32'd5, 32'd9};
    bus.i_wire_reader_done = 1'b0;
    bus.i_wire_reader_error = 1'b0;
    bus.i_wire_reader_error_type = 3'd0;
    #1;
    check("rst_reader_resetn", bus.o_wire_reader_resetn, 1'b0);
    check("rst_grant", bus.o_wire_grant, 4'd0);
    check("rst_router", bus.o_wire_reader_router, 4'd0);
    check("rst_busy", bus.o_wire_busy, 1'b0);
    check("rst_ack", bus.o_wire_ack, 4'd0);
    check("rst_address", bus.o_wire_reader_address, 128'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // single client 2 job, done 20 cycles after grant
    bus.i_wire_req = 4'b0100;
    tick();
    check("t1_grant", bus.o_wire_grant, 4'b0100);
    check("t1_router", bus.o_wire_reader_router, 4'b0100);
    check("t1_reader_resetn", bus.o_wire_reader_resetn, 1'b1);
    check("t1_busy", bus.o_wire_busy, 1'b1);
    check("t1_address", bus.o_wire_reader_address, 128'h1000 << 64);
    check("t1_length", bus.o_wire_reader_length, 128'd16 << 64);
    bus.i_wire_address[95:64] = 32'h5555_5555;
    bus.i_wire_address[31:0] = 32'h1234_5678;
    repeat (19) tick();
    check("t1_no_early_ack", bus.o_wire_ack, 4'd0);
    check("t1_address_latched", bus.o_wire_reader_address, 128'h1000 << 64);
    finish_job();
    check("t1_ack", bus.o_wire_ack, 4'b0100);
    check("t1_error", bus.o_wire_error, 1'b0);
    bus.i_wire_req = 4'd0;
    tick();
    check("t1_ack_pulse", bus.o_wire_ack, 4'd0);
    check("t1_recover_resetn", bus.o_wire_reader_resetn, 1'b0);
    check("t1_recover_grant", bus.o_wire_grant, 4'd0);
    check("t1_recover_address", bus.o_wire_reader_address, 128'd0);
    check("t1_recover_busy", bus.o_wire_busy, 1'b1);
    wait_idle();

    // all four requesting from reset: round robin with 3-cycle ack-to-grant gap
    resetn = 1'b0;
    bus.i_wire_req = 4'b1111;
    tick();
    resetn = 1'b1;
    tick();
    check("t2_first_grant", bus.o_wire_grant, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      exp_oh = 4'b0001 << k;
      check("t2_grant", bus.o_wire_grant, exp_oh);
      repeat (2) tick();
      finish_job();
      check("t2_ack", bus.o_wire_ack, exp_oh);
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.o_wire_grant == 4'd0 && n < 20);
      check("t2_gap", n, 3);
    end
    check("t2_wrap_grant", bus.o_wire_grant, 4'b0001);
    bus.i_wire_req = 4'd0;
    finish_job();
    wait_idle();

    // reader error on client 1, then a clean rerun
    bus.i_wire_req = 4'b0010;
    tick();
    check("t3_grant", bus.o_wire_grant, 4'b0010);
    repeat (3) tick();
    bus.i_wire_reader_error = 1'b1;
    bus.i_wire_reader_error_type = 3'b010;
    tick();
    bus.i_wire_reader_error = 1'b0;
    bus.i_wire_reader_error_type = 3'd0;
    check("t3_ack", bus.o_wire_ack, 4'b0010);
    check("t3_error", bus.o_wire_error, 1'b1);
    check("t3_error_type", bus.o_wire_error_type, 3'b010);
    tick();
    check("t3_hold1", bus.o_wire_reader_resetn, 1'b0);
    tick();
    check("t3_hold2", bus.o_wire_reader_resetn, 1'b0);
    tick();
    check("t3_release", bus.o_wire_reader_resetn, 1'b1);
    check("t3_regrant", bus.o_wire_grant, 4'b0010);
    bus.i_wire_req = 4'd0;
    finish_job();
    check("t3_clean_ack", bus.o_wire_ack, 4'b0010);
    check("t3_clean_error", bus.o_wire_error, 1'b0);
    check("t3_clean_type", bus.o_wire_error_type, 3'd0);
    wait_idle();

    // watchdog with WATCHDOG_BITS=6
    bus.i_wire_req = 4'b1000;
    tick();
    check("t4_grant", bus.o_wire_grant, 4'b1000);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.o_wire_ack == 4'd0 && n < 200);
    check("t4_latency", n, 64);
    check("t4_ack", bus.o_wire_ack, 4'b1000);
    check("t4_error", bus.o_wire_error, 1'b1);
    check("t4_error_type", bus.o_wire_error_type, 3'b111);
    bus.i_wire_req = 4'd0;
    wait_idle();

    // done and error together: error wins
    bus.i_wire_req = 4'b0001;
    tick();
    check("t5_grant", bus.o_wire_grant, 4'b0001);
    bus.i_wire_reader_done = 1'b1;
    bus.i_wire_reader_error = 1'b1;
    bus.i_wire_reader_error_type = 3'b101;
    tick();
    bus.i_wire_reader_done = 1'b0;
    bus.i_wire_reader_error = 1'b0;
    bus.i_wire_reader_error_type = 3'd0;
    check("t5_ack", bus.o_wire_ack, 4'b0001);
    check("t5_error", bus.o_wire_error, 1'b1);
    check("t5_error_type", bus.o_wire_error_type, 3'b101);
    bus.i_wire_req = 4'd0;
    wait_idle();

    // async reset mid-RUN; pointer (now 1) must return to client 0
    bus.i_wire_req = 4'b1001;
    tick();
    check("t6_grant", bus.o_wire_grant, 4'b1000);
    repeat (2) tick();
    resetn = 1'b0;
    #1;
    check("t6_rst_reader_resetn", bus.o_wire_reader_resetn, 1'b0);
    check("t6_rst_router", bus.o_wire_reader_router, 4'd0);
    check("t6_rst_grant", bus.o_wire_grant, 4'd0);
    check("t6_rst_busy", bus.o_wire_busy, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    check("t6_regrant", bus.o_wire_grant, 4'b0001);
    check("t6_reader_resetn", bus.o_wire_reader_resetn, 1'b1);
    bus.i_wire_req = 4'd0;
    finish_job();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
